// File: rtl/fp_pkg.sv
// fp_pkg: shared field widths, constants, flag indices and state encoding for the float-to-int converter
package fp_pkg;
    localparam int EXP_W = 8;
    localparam int FRAC_W = 23;
    localparam logic [EXP_W-1:0] EXP_BIAS = 8'd127;
    localparam logic [EXP_W-1:0] ALIGN_EXP = 8'd150;
    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam int FLG_INVALID = 2;
    localparam int FLG_OVF = 1;
    localparam int FLG_INEXACT = 0;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/fp_classify.sv
// fp_classify: splits a single-precision word and classifies it for integer conversion
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0]       in_data,
    output logic              sign,
    output logic [FRAC_W-1:0] frac,
    output logic              is_nan_inf,
    output logic              is_small,
    output logic              is_int_min,
    output logic              is_ovf,
    output logic [4:0]        shamt,
    output logic              shl
);
    logic [EXP_W-1:0] e;
    // Field split, special-case detection and alignment distance relative to the integer point
    always_comb begin
        sign = in_data[31];
        e = in_data[30:23];
        frac = in_data[22:0];
        is_nan_inf = e == 8'd255;
        is_small = e < EXP_BIAS;
        is_int_min = in_data == 32'hCF00_0000;
        is_ovf = e >= 8'd158;
        shl = e > ALIGN_EXP;
        shamt = shl ? 5'(e - ALIGN_EXP) : 5'(ALIGN_EXP - e);
    end
endmodule

// File: rtl/fp_to_int_seq.sv
// fp_to_int_seq: float to saturating signed 32-bit integer, one shifter bit per cycle, valid/ready on both sides
module fp_to_int_seq
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_flags
);
    state_t state_q, state_d;
    logic in_ready_q, in_ready_d;
    logic out_valid_q, out_valid_d;
    logic [31:0] mag_q, mag_d;
    logic [31:0] data_q, data_d;
    logic [2:0] flags_q, flags_d;
    logic [4:0] cnt_q, cnt_d;
    logic dir_q, dir_d;
    logic neg_q, neg_d;
    logic sticky_q, sticky_d;
    logic sign, is_nan_inf, is_small, is_int_min, is_ovf, shl;
    logic [FRAC_W-1:0] frac;
    logic [4:0] shamt;

    fp_classify u_cls (
        .in_data    (in_data),
        .sign       (sign),
        .frac       (frac),
        .is_nan_inf (is_nan_inf),
        .is_small   (is_small),
        .is_int_min (is_int_min),
        .is_ovf     (is_ovf),
        .shamt      (shamt),
        .shl        (shl)
    );

    assign in_ready = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data = data_q;
    assign out_flags = flags_q;

    // Specials preload their final magnitude with zero shift, so every path finishes through the same negate step
    always_comb begin
        state_d = state_q;
        in_ready_d = in_ready_q;
        out_valid_d = out_valid_q;
        mag_d = mag_q;
        data_d = data_q;
        flags_d = flags_q;
        cnt_d = cnt_q;
        dir_d = dir_q;
        neg_d = neg_q;
        sticky_d = sticky_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SHIFT;
                    in_ready_d = 1'b0;
                    flags_d = '0;
                    sticky_d = 1'b0;
                    cnt_d = '0;
                    dir_d = 1'b0;
                    neg_d = 1'b0;
                    if (is_nan_inf) begin
                        flags_d[FLG_INVALID] = 1'b1;
                        mag_d = (sign && frac == '0) ? INT_MIN : INT_MAX;
                    end else if (is_small) begin
                        flags_d[FLG_INEXACT] = |in_data[30:0];
                        mag_d = '0;
                    end else if (is_int_min) begin
                        mag_d = INT_MIN;
                    end else if (is_ovf) begin
                        flags_d[FLG_OVF] = 1'b1;
                        mag_d = sign ? INT_MIN : INT_MAX;
                    end else begin
                        mag_d = {8'b0, 1'b1, frac};
                        cnt_d = shamt;
                        dir_d = shl;
                        neg_d = sign;
                    end
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 5'd1;
                    mag_d = dir_q ? mag_q << 1 : mag_q >> 1;
                    sticky_d = sticky_q | (~dir_q & mag_q[0]);
                end else begin
                    data_d = neg_q ? -mag_q : mag_q;
                    flags_d[FLG_INEXACT] = flags_q[FLG_INEXACT] | sticky_q;
                    out_valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any conversion in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            in_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            mag_q <= '0;
            data_q <= '0;
            flags_q <= '0;
            cnt_q <= '0;
            dir_q <= 1'b0;
            neg_q <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q <= state_d;
            in_ready_q <= in_ready_d;
            out_valid_q <= out_valid_d;
            mag_q <= mag_d;
            data_q <= data_d;
            flags_q <= flags_d;
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            neg_q <= neg_d;
            sticky_q <= sticky_d;
        end
    end
endmodule

// File: tb/tb_fp_to_int_seq.sv
// tb_fp_to_int_seq: directed conversions with hand-computed results, latencies and handshake checks
module tb_fp_to_int_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [31:0] in_data = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [31:0] out_data;
    logic [2:0] out_flags;
    int tests = 0;
    int fails = 0;

    fp_to_int_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic convert(input string tag, input logic [31:0] x, input logic [31:0] exp_d,
                           input logic [2:0] exp_f, input int exp_lat, input int hold);
        int lat;
        @(negedge clk);
        chk({tag, " ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data = x;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = 32'hDEAD_BEEF;
        chk({tag, " busy"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " data"}, out_data, exp_d);
        chk({tag, " flags"}, 32'(out_flags), 32'(exp_f));
        if (hold > 0) begin
            in_valid = 1'b1;
            in_data = 32'h3F80_0000;
            repeat (hold) @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk({tag, " hold data"}, out_data, exp_d);
            chk({tag, " hold valid"}, 32'(out_valid), 32'd1);
            chk({tag, " hold ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, " release"}, 32'(in_ready), 32'd1);
        chk({tag, " drop valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data", out_data, 32'd0);
        chk("rst out_flags", 32'(out_flags), 32'd0);
        convert("pi", 32'h4049_0FDB, 32'h0000_0003, 3'b001, 23, 0);
        convert("m2", 32'hC000_0000, 32'hFFFF_FFFE, 3'b000, 23, 5);
        convert("p2_30", 32'h4E80_0000, 32'h4000_0000, 3'b000, 8, 0);
        convert("p2_31", 32'h4F00_0000, 32'h7FFF_FFFF, 3'b010, 1, 0);
        convert("m2_31", 32'hCF00_0000, 32'h8000_0000, 3'b000, 1, 0);
        convert("m2_32", 32'hCF80_0000, 32'h8000_0000, 3'b010, 1, 0);
        convert("nan", 32'h7FC0_0000, 32'h7FFF_FFFF, 3'b100, 1, 0);
        convert("ninf", 32'hFF80_0000, 32'h8000_0000, 3'b100, 1, 0);
        convert("half", 32'h3F00_0000, 32'h0000_0000, 3'b001, 1, 0);
        convert("zero", 32'h0000_0000, 32'h0000_0000, 3'b000, 1, 0);
        convert("denorm", 32'h8000_0001, 32'h0000_0000, 3'b001, 1, 0);
        convert("m1p5", 32'hBFC0_0000, 32'hFFFF_FFFF, 3'b001, 24, 0);
        convert("p8m", 32'h4B7F_FFFF, 32'h00FF_FFFF, 3'b000, 1, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 32'h3F80_0001;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst out_data", out_data, 32'd0);
        convert("one", 32'h3F80_0000, 32'h0000_0001, 3'b000, 24, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fp_to_int_seq.md
# fp_to_int_seq

Sequential IEEE-754 single-precision to signed 32-bit integer converter: the decode-direction counterpart to the floating-point adder. The adder packs sign/exponent/mantissa into a float word; this block unpacks a float word back into a two's-complement integer. It sits on the chip's result path so that float results can feed integer consumers. It uses a valid/ready handshake on both sides and aligns the mantissa with a one-bit-per-cycle shifter, which keeps the area small in place of a barrel shifter.

## Interface
- Parameters: none; all widths are fixed by the IEEE-754 single format.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `in_data` holds a float to convert.
- `in_ready` output 1: block idle and able to accept; registered.
- `in_data` input 32: IEEE-754 single, {sign, exp[7:0], frac[22:0]}.
- `out_valid` output 1: `out_data` and `out_flags` are valid.
- `out_ready` input 1: downstream consumer accepts the result.
- `out_data` output 32: signed integer result, rounded toward zero (truncated), saturating.
- `out_flags` output 3: {invalid, overflow, inexact}.

## Operation
- **Field split:** s = in_data[31], e = in_data[30:23], f = in_data[22:0].
- **States:**
  - IDLE: in_ready=1.
  - SHIFT: iterative alignment.
  - DONE: out_valid=1, holding the result.
- **Accept:** in_valid & in_ready in IDLE. On accept, classify the input and load the shifter.
- **Special cases** (load the final value directly, N=0):
  - e=255 (Inf/NaN): invalid=1. Result 0x80000000 if the input is -Inf, else 0x7FFFFFFF (+Inf and every NaN).
  - e<127 (|x|<1, including zero and denormals): result 0. inexact=1 iff e!=0 or f!=0.
  - in_data==0xCF000000 (exactly -2^31): result 0x80000000, no flags.
  - e>=158, otherwise: overflow=1. Result 0x7FFFFFFF if s=0, else 0x80000000.
- **Normal range, 127<=e<=157:**
  - Load mag = {8'b0, 1'b1, f}.
  - Load N = |e-150| and direction = left if e>150, else right.
  - Each SHIFT cycle with cnt!=0: shift mag one bit and decrement cnt.
  - On a right shift, the bit shifted out ORs into a sticky bit, which becomes inexact.
- **Finish:** when cnt==0 in SHIFT, result = s ? -mag : mag, computed as a 32-bit two's complement. Then go to DONE.
- **Release:** DONE holds out_data and out_flags stable while out_ready=0. On out_valid & out_ready, go to IDLE.
- **Flags:** flags cleared on every accept; at most one of invalid or overflow is set per conversion.
- **Throughput:** no overlap; a new input is accepted only in IDLE.

## Timing
- **Reset values:** state=IDLE, in_ready=1, out_valid=0, out_data=0, out_flags=0, cnt=0, sticky=0.
- **Latency:** accept at edge k → out_valid=1 after edge k+1+N.
  - Specials: N=0, so latency is 1 cycle.
  - Normal range: N is 0..23 (e=150 gives 0; e=127 gives 23; e=157 gives 7).
- **Handshake turnaround:**
  - in_ready falls after the accept edge.
  - in_ready rises the cycle after the out_valid & out_ready edge.
  - Minimum cycle-to-cycle throughput is N+3 cycles.
- **Input side:** in_valid asserted outside IDLE is ignored; in_data is sampled only on the accept edge.
- **Reset:** rst in any state forces reset values on that edge and drops any in-flight conversion. rst dominates a simultaneous accept.
- **Output side:** out_ready asserted while out_valid=0 has no effect.

## Structure
- **Package `fp_pkg`:**
  - Field widths: EXP_W=8, FRAC_W=23.
  - Constants: EXP_BIAS=127, ALIGN_EXP=150, INT_MAX=32'h7FFFFFFF, INT_MIN=32'h80000000.
  - Flag bit indices: FLG_INVALID=2, FLG_OVF=1, FLG_INEXACT=0.
  - State enum: IDLE, SHIFT, DONE.
- **Sub-module `fp_classify`:** combinational. Splits the fields and emits is_nan_inf, is_small, is_int_min, is_ovf, the shift count N and the shift direction. The sequential top instantiates it once.

## Test plan
- 0x40490FDB (3.14159) → out_data 0x00000003, flags 3'b001; out_valid 23 cycles after the accept edge (N=22).
- 0xC0000000 (-2.0) → 0xFFFFFFFE, flags 3'b000. Then hold out_ready=0 for 5 cycles: data is stable and in_ready stays 0.
- 0x4E800000 (2^30) → 0x40000000, flags 0, left shift N=7. Then 0x4F000000 (2^31) → 0x7FFFFFFF with flags 3'b010, and 0xCF000000 → 0x80000000 with flags 0.
- 0x7FC00000 (NaN) → 0x7FFFFFFF, flags 3'b100; 0xFF800000 (-Inf) → 0x80000000, flags 3'b100; both with 1-cycle latency.
- 0x3F000000 (0.5) → 0, flags 3'b001; 0x00000000 → 0, flags 0; 0x80000001 (denormal) → 0, flags 3'b001.
- Reset mid-operation: assert rst during SHIFT of 0x3F800001 → next cycle in_ready=1 and out_valid=0. A following 0x3F800000 (1.0) → 0x00000001 with flags 0.
